isp_wb: RTL and testbench

- Bayer-domain white-balance gain stage placed directly downstream of `isp_bnr`.
- Consumes the denoised raw stream and applies a per-channel R/Gr/Gb/B digital gain with rounding and saturation.
- Emits a raw stream in the same format and timing style, with the sync signals delayed to match.
- Accumulates per-frame channel sums of the input for the AWB firmware loop.

---
 rtl/isp_pkg.sv | 20 ++
 rtl/isp_wb_mul.sv | 54 +++++
 rtl/isp_wb.sv | 216 +++++++++++++++++++++
 tb/tb_isp_wb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared ISP definitions: Bayer phase codes and the 3.5 fixed-point gain format.
package isp_pkg;

    typedef enum logic [1:0] {
        FMT_R  = 2'd0,
        FMT_GR = 2'd1,
        FMT_GB = 2'd2,
        FMT_B  = 2'd3
    } bayer_fmt_e;

    localparam int         GAIN_FRAC  = 5;
    localparam logic [7:0] GAIN_UNITY = 8'd32;

    function automatic bayer_fmt_e cfa_fmt(input logic [1:0] bayer,
                                           input logic       odd_line,
                                           input logic       odd_pix);
        return bayer_fmt_e'(bayer ^ {odd_line, odd_pix});
    endfunction

endpackage

// File: rtl/isp_wb_mul.sv
// White-balance arithmetic: raw x gain, round half up, clip to BITS.
// Two register stages; keep_i (aligned with the second stage) forces blanking to 0.
module isp_wb_mul #(
    parameter int BITS      = 8,
    parameter int GAIN_FRAC = isp_pkg::GAIN_FRAC
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [BITS-1:0] raw_i,
    input  logic [7:0]      gain_i,
    input  logic            keep_i,
    output logic [BITS-1:0] pix_o
);
    localparam int            PW      = BITS + 8;
    localparam int            RW      = PW - GAIN_FRAC;
    localparam logic [PW-1:0] ROUND_C = {{(PW - 1){1'b0}}, 1'b1} << (GAIN_FRAC - 1);

    logic [PW-1:0]   prod_d;
    logic [PW-1:0]   prod_q;
    logic [RW-1:0]   scaled_s;
    logic [BITS-1:0] pix_d;
    logic [BITS-1:0] pix_q;

    // Full-precision product; PW bits cannot overflow for an 8-bit gain.
    always_comb begin
        prod_d = {8'd0, raw_i} * {{BITS{1'b0}}, gain_i};
    end

    // Round, drop the fraction and clip anything above full scale.
    always_comb begin
        scaled_s = RW'((prod_q + ROUND_C) >> GAIN_FRAC);
        if (!keep_i) begin
            pix_d = {BITS{1'b0}};
        end else if (|scaled_s[RW-1:BITS]) begin
            pix_d = {BITS{1'b1}};
        end else begin
            pix_d = scaled_s[BITS-1:0];
        end
    end

    // Product and result registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prod_q <= {PW{1'b0}};
            pix_q  <= {BITS{1'b0}};
        end else begin
            prod_q <= prod_d;
            pix_q  <= pix_d;
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/isp_wb.sv
// Bayer white-balance gain stage (3-cycle latency) with per-frame AWB sums.
// Define ISP_WB_STAT_EN to build the accumulators; otherwise stat_* are tied to 0.
module isp_wb
    import isp_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int WIDTH     = 1280,
    parameter int HEIGHT    = 960,
    parameter int BAYER     = 0,
    parameter int STAT_BITS = 32
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic [7:0]           gain_r,
    input  logic [7:0]           gain_gr,
    input  logic [7:0]           gain_gb,
    input  logic [7:0]           gain_b,
    input  logic                 in_href,
    input  logic                 in_vsync,
    input  logic                 in_de,
    input  logic [BITS-1:0]      in_raw,
    output logic                 out_href,
    output logic                 out_vsync,
    output logic                 out_de,
    output logic [BITS-1:0]      out_raw,
    output logic [STAT_BITS-1:0] stat_r_sum,
    output logic [STAT_BITS-1:0] stat_g_sum,
    output logic [STAT_BITS-1:0] stat_b_sum,
    output logic                 stat_valid
);
    localparam logic [1:0]      BAYER_C = 2'(BAYER);
    localparam logic [BITS-1:0] RAW_MAX = {BITS{1'b1}};

    if (WIDTH < 2 || HEIGHT < 2) begin : g_bad_geometry
        $error("isp_wb: a Bayer frame needs at least 2x2 pixels");
    end

    logic            vsync_prev_q;
    logic            href_prev_q;
    logic            odd_pix_q;
    logic            odd_pix_d;
    logic            odd_line_q;
    logic            odd_line_d;
    logic            vs_rise_s;
    bayer_fmt_e      fmt_s;
    logic [7:0]      gain_r_q;
    logic [7:0]      gain_gr_q;
    logic [7:0]      gain_gb_q;
    logic [7:0]      gain_b_q;
    logic [7:0]      gain_sel_s;
    logic [BITS-1:0] raw_s1_q;
    logic [7:0]      gain_s1_q;
    logic [2:0]      href_sr_q;
    logic [2:0]      vsync_sr_q;
    logic [2:0]      de_sr_q;
    logic [BITS-1:0] pix_s;

    // Frame-start detect, CFA phase tracking and per-phase gain select.
    always_comb begin
        vs_rise_s = in_vsync & ~vsync_prev_q;
        if (in_href) begin
            odd_pix_d = ~odd_pix_q;
        end else begin
            odd_pix_d = 1'b0;
        end
        if (in_vsync) begin
            odd_line_d = 1'b0;
        end else if (href_prev_q && !in_href) begin
            odd_line_d = ~odd_line_q;
        end else begin
            odd_line_d = odd_line_q;
        end
        fmt_s = cfa_fmt(BAYER_C, odd_line_q, odd_pix_q);
        case (fmt_s)
            FMT_R:   gain_sel_s = gain_r_q;
            FMT_GR:  gain_sel_s = gain_gr_q;
            FMT_GB:  gain_sel_s = gain_gb_q;
            FMT_B:   gain_sel_s = gain_b_q;
            default: gain_sel_s = GAIN_UNITY;
        endcase
    end

    // Phase state, frame-stable gain shadows, S1 and sync delay lines.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            odd_pix_q    <= 1'b0;
            odd_line_q   <= 1'b0;
            gain_r_q     <= GAIN_UNITY;
            gain_gr_q    <= GAIN_UNITY;
            gain_gb_q    <= GAIN_UNITY;
            gain_b_q     <= GAIN_UNITY;
            raw_s1_q     <= {BITS{1'b0}};
            gain_s1_q    <= 8'd0;
            href_sr_q    <= 3'd0;
            vsync_sr_q   <= 3'd0;
            de_sr_q      <= 3'd0;
        end else begin
            vsync_prev_q <= in_vsync;
            href_prev_q  <= in_href;
            odd_pix_q    <= odd_pix_d;
            odd_line_q   <= odd_line_d;
            if (vs_rise_s) begin
                gain_r_q  <= gain_r;
                gain_gr_q <= gain_gr;
                gain_gb_q <= gain_gb;
                gain_b_q  <= gain_b;
            end
            raw_s1_q   <= in_raw;
            gain_s1_q  <= gain_sel_s;
            href_sr_q  <= {href_sr_q[1:0], in_href};
            vsync_sr_q <= {vsync_sr_q[1:0], in_vsync};
            de_sr_q    <= {de_sr_q[1:0], in_de};
        end
    end

    // href_sr_q[1] is the line-valid that lands in out_href with the result.
    isp_wb_mul #(
        .BITS      (BITS),
        .GAIN_FRAC (GAIN_FRAC)
    ) u_mul (
        .clk_i   (pclk),
        .rst_n_i (rst_n),
        .raw_i   (raw_s1_q),
        .gain_i  (gain_s1_q),
        .keep_i  (href_sr_q[1]),
        .pix_o   (pix_s)
    );

    assign out_href  = href_sr_q[2];
    assign out_vsync = vsync_sr_q[2];
    assign out_de    = de_sr_q[2];
    assign out_raw   = pix_s;

`ifdef ISP_WB_STAT_EN
    logic [STAT_BITS-1:0] acc_r_q;
    logic [STAT_BITS-1:0] acc_g_q;
    logic [STAT_BITS-1:0] acc_b_q;
    logic [STAT_BITS-1:0] acc_r_d;
    logic [STAT_BITS-1:0] acc_g_d;
    logic [STAT_BITS-1:0] acc_b_d;
    logic [STAT_BITS-1:0] sum_r_q;
    logic [STAT_BITS-1:0] sum_g_q;
    logic [STAT_BITS-1:0] sum_b_q;
    logic                 stat_valid_q;
    logic                 count_s;

    function automatic logic [STAT_BITS-1:0] sat_add(input logic [STAT_BITS-1:0] acc,
                                                     input logic [BITS-1:0]      pix);
        logic [STAT_BITS:0] sum;
        sum = {1'b0, acc} + {{(STAT_BITS + 1 - BITS){1'b0}}, pix};
        if (sum[STAT_BITS]) begin
            return {STAT_BITS{1'b1}};
        end else begin
            return sum[STAT_BITS-1:0];
        end
    endfunction

    // Pre-gain accumulation; clipped pixels are left out of the AWB sums.
    always_comb begin
        count_s = in_href & ~in_vsync & (in_raw != RAW_MAX);
        acc_r_d = acc_r_q;
        acc_g_d = acc_g_q;
        acc_b_d = acc_b_q;
        if (vs_rise_s) begin
            acc_r_d = {STAT_BITS{1'b0}};
            acc_g_d = {STAT_BITS{1'b0}};
            acc_b_d = {STAT_BITS{1'b0}};
        end else if (count_s) begin
            case (fmt_s)
                FMT_R:          acc_r_d = sat_add(acc_r_q, in_raw);
                FMT_GR, FMT_GB: acc_g_d = sat_add(acc_g_q, in_raw);
                FMT_B:          acc_b_d = sat_add(acc_b_q, in_raw);
                default:        acc_b_d = acc_b_q;
            endcase
        end else begin
            acc_r_d = acc_r_q;
        end
    end

    // Accumulators plus the sums published at each frame start.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r_q      <= {STAT_BITS{1'b0}};
            acc_g_q      <= {STAT_BITS{1'b0}};
            acc_b_q      <= {STAT_BITS{1'b0}};
            sum_r_q      <= {STAT_BITS{1'b0}};
            sum_g_q      <= {STAT_BITS{1'b0}};
            sum_b_q      <= {STAT_BITS{1'b0}};
            stat_valid_q <= 1'b0;
        end else begin
            acc_r_q      <= acc_r_d;
            acc_g_q      <= acc_g_d;
            acc_b_q      <= acc_b_d;
            stat_valid_q <= vs_rise_s;
            if (vs_rise_s) begin
                sum_r_q <= acc_r_q;
                sum_g_q <= acc_g_q;
                sum_b_q <= acc_b_q;
            end
        end
    end

    assign stat_r_sum = sum_r_q;
    assign stat_g_sum = sum_g_q;
    assign stat_b_sum = sum_b_q;
    assign stat_valid = stat_valid_q;
`else
    assign stat_r_sum = {STAT_BITS{1'b0}};
    assign stat_g_sum = {STAT_BITS{1'b0}};
    assign stat_b_sum = {STAT_BITS{1'b0}};
    assign stat_valid = 1'b0;
`endif

endmodule

// File: tb/tb_isp_wb.sv
// Self-checking bench for isp_wb: frame-level reference model plus literal spot checks.
module tb_isp_wb;
    localparam int BITS = 8;
`ifdef ISP_WB_STAT_EN
    localparam bit STAT_ON = 1'b1;
`else
    localparam bit STAT_ON = 1'b0;
`endif
    localparam int SEL_RAW = 0, SEL_SR = 1, SEL_SG = 2, SEL_SB = 3, SEL_SV = 4, SEL_HREF = 5;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  gain_r = 8'd32, gain_gr = 8'd32, gain_gb = 8'd32, gain_b = 8'd32;
    logic        in_href = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
    logic [7:0]  in_raw = 8'd0;
    logic        out_href, out_vsync, out_de, stat_valid;
    logic [7:0]  out_raw;
    logic [31:0] stat_r_sum, stat_g_sum, stat_b_sum;

    int n_chk = 0;
    int n_pass = 0;

    always #5 pclk = ~pclk;

    isp_wb #(.BITS(8), .WIDTH(1280), .HEIGHT(960), .BAYER(0), .STAT_BITS(32)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .gain_r(gain_r), .gain_gr(gain_gr), .gain_gb(gain_gb), .gain_b(gain_b),
        .in_href(in_href), .in_vsync(in_vsync), .in_de(in_de), .in_raw(in_raw),
        .out_href(out_href), .out_vsync(out_vsync), .out_de(out_de), .out_raw(out_raw),
        .stat_r_sum(stat_r_sum), .stat_g_sum(stat_g_sum), .stat_b_sum(stat_b_sum),
        .stat_valid(stat_valid)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       href;
        logic       vsync;
        logic       de;
        logic [7:0] raw;
    } obs_t;

    obs_t   pipe0 = '0, pipe1 = '0, pipe2 = '0;
    int     m_gain [4];          // indexed by colour: 0 R, 1 Gr, 2 Gb, 3 B
    int     m_x, m_y;            // pixel index in line, line index in frame
    bit     m_prev_vs, m_prev_href;
    longint m_acc [3];           // 0 R, 1 G, 2 B
    longint m_sum [3];
    bit     m_valid;
    // RGGB layout: row 0 = R Gr, row 1 = Gb B
    int     cfa_colour [4] = '{0, 1, 2, 3};
    int     colour_group [4] = '{0, 1, 1, 2};

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_gain[k] = 32;
        for (int k = 0; k < 3; k++) begin m_acc[k] = 0; m_sum[k] = 0; end
        m_x = 0; m_y = 0; m_prev_vs = 1'b0; m_prev_href = 1'b0; m_valid = 1'b0;
        pipe0 = '0; pipe1 = '0; pipe2 = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge pclk);
            if (!rst_n) begin
                model_reset();
            end else begin
                obs_t   e;
                int     col, v;
                longint s;
                col = cfa_colour[(m_y % 2) * 2 + (m_x % 2)];
                v = (int'(in_raw) * m_gain[col] + 16) / 32;
                if (v > 255) v = 255;
                e.href = in_href; e.vsync = in_vsync; e.de = in_de;
                e.raw = in_href ? 8'(v) : 8'd0;
                pipe2 = pipe1; pipe1 = pipe0; pipe0 = e;
                m_valid = 1'b0;
                if (in_vsync && !m_prev_vs) begin
                    for (int k = 0; k < 3; k++) begin m_sum[k] = m_acc[k]; m_acc[k] = 0; end
                    m_valid = 1'b1;
                    m_gain[0] = gain_r; m_gain[1] = gain_gr; m_gain[2] = gain_gb; m_gain[3] = gain_b;
                end else if (in_href && !in_vsync && in_raw != 8'd255) begin
                    s = m_acc[colour_group[col]] + longint'(in_raw);
                    m_acc[colour_group[col]] = (s > 64'd4294967295) ? 64'd4294967295 : s;
                end
                if (in_href) m_x = m_x + 1; else m_x = 0;
                if (in_vsync) m_y = 0;
                else if (m_prev_href && !in_href) m_y = m_y + 1;
                m_prev_vs = in_vsync; m_prev_href = in_href;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            longint er, eg, eb;
            bit     ev;
            @(posedge pclk);
            #2;
            n_chk++;
            if (out_href === pipe2.href && out_vsync === pipe2.vsync && out_de === pipe2.de && out_raw === pipe2.raw)
                n_pass++;
            else
                $display("FAIL pix_path t=%0t: got href=%b vs=%b de=%b raw=%0d, expected href=%b vs=%b de=%b raw=%0d",
                         $time, out_href, out_vsync, out_de, out_raw, pipe2.href, pipe2.vsync, pipe2.de, pipe2.raw);
            er = STAT_ON ? m_sum[0] : 0;
            eg = STAT_ON ? m_sum[1] : 0;
            eb = STAT_ON ? m_sum[2] : 0;
            ev = STAT_ON ? m_valid : 1'b0;
            n_chk++;
            if (longint'(stat_r_sum) == er && longint'(stat_g_sum) == eg && longint'(stat_b_sum) == eb && stat_valid === ev)
                n_pass++;
            else
                $display("FAIL stats t=%0t: got r=%0d g=%0d b=%0d v=%b, expected r=%0d g=%0d b=%0d v=%b",
                         $time, stat_r_sum, stat_g_sum, stat_b_sum, stat_valid, er, eg, eb, ev);
        end
    end

    // ---------------- literal spot checks ----------------
    task automatic check_lit(input int sel, input longint expv, input string nm);
        longint act;
        case (sel)
            SEL_RAW:  act = longint'(out_raw);
            SEL_SR:   act = longint'(stat_r_sum);
            SEL_SG:   act = longint'(stat_g_sum);
            SEL_SB:   act = longint'(stat_b_sum);
            SEL_SV:   act = longint'(stat_valid);
            SEL_HREF: act = longint'(out_href);
            default:  act = -1;
        endcase
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    // Check a DUT output 'edges' rising edges after the current point.
    task automatic lit(input int edges, input int sel, input longint expv, input string nm);
        fork
            begin
                repeat (edges) @(posedge pclk);
                #2;
                check_lit(sel, expv, nm);
            end
        join_none
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input logic h, input logic v, input logic d, input logic [7:0] r);
        @(negedge pclk);
        in_href = h; in_vsync = v; in_de = d; in_raw = r;
    endtask

    task automatic blank(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic set_gains(input logic [7:0] r, input logic [7:0] gr, input logic [7:0] gb, input logic [7:0] b);
        gain_r = r; gain_gr = gr; gain_gb = gb; gain_b = b;
    endtask

    task automatic frame_start(input logic [7:0] r, input logic [7:0] gr, input logic [7:0] gb, input logic [7:0] b);
        set_gains(r, gr, gb, b);
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        blank(2);
    endtask

    task automatic line4(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3);
        drive(1'b1, 1'b0, 1'b1, p0);
        drive(1'b1, 1'b0, 1'b1, p1);
        drive(1'b1, 1'b0, 1'b1, p2);
        drive(1'b1, 1'b0, 1'b1, p3);
        blank(3);
    endtask

    initial begin
        repeat (3) @(negedge pclk);
        rst_n = 1'b1;
        blank(2);

        // Unity gain ramp 0..254 over two lines, de toggling independently.
        frame_start(8'd32, 8'd32, 8'd32, 8'd32);
        for (int i = 0; i < 128; i++) begin
            drive(1'b1, 1'b0, (i % 5) != 0, 8'(i));
            if (i == 77) lit(3, SEL_RAW, 77, "ramp_77");
        end
        blank(3);
        for (int i = 128; i < 255; i++) begin
            drive(1'b1, 1'b0, (i % 7) != 0, 8'(i));
            if (i == 254) lit(3, SEL_RAW, 254, "ramp_254");
        end
        blank(3);

        // Per-channel gains, saturation and rounding.
        frame_start(8'd64, 8'd48, 8'd32, 8'd32);
        drive(1'b1, 1'b0, 1'b1, 8'd100); lit(3, SEL_RAW, 200, "r_gain_100");
        drive(1'b1, 1'b0, 1'b1, 8'd101); lit(3, SEL_RAW, 152, "gr_round_101");
        drive(1'b1, 1'b0, 1'b1, 8'd200); lit(3, SEL_RAW, 255, "r_sat_200");
        drive(1'b1, 1'b0, 1'b1, 8'd0);
        blank(3);
        line4(8'd50, 8'd50, 8'd50, 8'd50);

        // Mid-frame gain change waits for the next frame.
        frame_start(8'd32, 8'd32, 8'd32, 8'd32);
        line4(8'd1, 8'd2, 8'd3, 8'd4);
        gain_b = 8'd96;
        drive(1'b1, 1'b0, 1'b1, 8'd50);
        drive(1'b1, 1'b0, 1'b1, 8'd50); lit(3, SEL_RAW, 50, "b_gain_held");
        blank(3);
        frame_start(8'd32, 8'd32, 8'd32, 8'd96);
        line4(8'd9, 8'd9, 8'd9, 8'd9);
        drive(1'b1, 1'b0, 1'b1, 8'd50);
        drive(1'b1, 1'b0, 1'b1, 8'd50); lit(3, SEL_RAW, 150, "b_gain_new");
        blank(3);

        // 4x2 statistics frame with one clipped R pixel.
        frame_start(8'd32, 8'd32, 8'd32, 8'd32);
        line4(8'd10, 8'd20, 8'd255, 8'd20);
        line4(8'd20, 8'd30, 8'd20, 8'd30);
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        lit(1, SEL_SR, STAT_ON ? 10 : 0, "stat_r");
        lit(1, SEL_SG, STAT_ON ? 80 : 0, "stat_g");
        lit(1, SEL_SB, STAT_ON ? 60 : 0, "stat_b");
        lit(1, SEL_SV, STAT_ON ? 1 : 0, "stat_valid_pulse");
        lit(2, SEL_SV, 0, "stat_valid_one_cycle");
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        blank(2);
        drive(1'b1, 1'b0, 1'b1, 8'd5);
        drive(1'b1, 1'b0, 1'b1, 8'd7);
        blank(3);
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        lit(1, SEL_SR, STAT_ON ? 5 : 0, "stat_r_restart");
        lit(1, SEL_SG, STAT_ON ? 7 : 0, "stat_g_restart");
        lit(1, SEL_SB, 0, "stat_b_restart");
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        blank(2);

        // Reset in the middle of a line.
        set_gains(8'd64, 8'd64, 8'd64, 8'd64);
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        blank(2);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 8'd100);
        lit(0, SEL_HREF, 1, "href_before_reset");
        drive(1'b1, 1'b0, 1'b1, 8'd100);
        rst_n = 1'b0;
        lit(0, SEL_RAW, 0, "reset_raw");
        lit(0, SEL_HREF, 0, "reset_href");
        lit(0, SEL_SV, 0, "reset_valid");
        blank(1);
        blank(1);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'd100); lit(3, SEL_RAW, 100, "reset_gain_unity");
        drive(1'b1, 1'b0, 1'b1, 8'd60);
        blank(3);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b0;
        blank(1);
        rst_n = 1'b1;
        blank(2);
        set_gains(8'd32, 8'd32, 8'd32, 8'd32);
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        lit(1, SEL_SR, 0, "first_vs_r");
        lit(1, SEL_SG, 0, "first_vs_g");
        lit(1, SEL_SV, STAT_ON ? 1 : 0, "first_vs_valid");
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        blank(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
